mem_access_unit: RTL

- MEM-stage load/store sequencer sitting directly upstream of memory_block.
- Accepts one load/store request at a time from the EX/MEM boundary through a valid/ready handshake.
- Drives memory_block's address, data, byte-select and read/write strobes with a fixed setup/strobe/hold sequence.
- Returns a registered response (load data, destination tag, error flag) to writeback through a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_access_unit_load_extend.sv | 25 ++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: state encoding,
// default widths and the request address fault check.
package mem_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      HOLD   = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Address outside memory_block's range, or a misaligned word access.
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input logic        is_byte,
                                       input int unsigned addr_w);
      logic out_of_range_s;
      logic misaligned_s;
      out_of_range_s = ((addr >> addr_w) != 32'd0);
      misaligned_s   = !is_byte && (addr[1:0] != 2'b00);
      return out_of_range_s || misaligned_s;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data formatting: byte/word select with sign or zero extension.
module load_extend #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] raw,
   input  logic              is_byte,
   input  logic              is_signed,
   output logic [DATA_W-1:0] ext
);

   // Byte loads keep bits [7:0]; the upper bits follow is_signed.
   always_comb begin
      ext = raw;
      if (is_byte) begin
         if (is_signed) begin
            ext = {{(DATA_W-8){raw[7]}}, raw[7:0]};
         end else begin
            ext = {{(DATA_W-8){1'b0}}, raw[7:0]};
         end
      end else begin
         ext = raw;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one request at a time, fixed
// setup/strobe/hold sequence toward memory_block, registered response.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = 2,
   parameter int TAG_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_byteOperations,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   state_t            state_r, next_state_s;
   logic [CNT_W-1:0]  cnt_r, next_cnt_s;
   logic              write_r, byte_r, signed_r;
   logic [31:0]       addr_r;
   logic [DATA_W-1:0] wdata_r, load_r, ext_s;
   logic [TAG_W-1:0]  tag_r;
   logic              accept_s, fault_s, drive_s;
   logic              cur_write_s, cur_byte_s;
   logic [31:0]       cur_addr_s;
   logic [DATA_W-1:0] cur_wdata_s;

   assign accept_s = req_valid && (state_r == IDLE);
   assign fault_s  = addr_fault(req_addr, req_byte, ADDR_W);

   // Next-state and latency counter.
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = {CNT_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               next_state_s = fault_s ? RESP : SETUP;
            end else begin
               next_state_s = IDLE;
            end
         end
         SETUP:  next_state_s = ACCESS;
         ACCESS: begin
            if (cnt_r == CNT_LAST) begin
               next_state_s = HOLD;
            end else begin
               next_cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         HOLD: next_state_s = RESP;
         RESP: begin
            if (resp_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // On the accepting edge the request registers are not loaded yet, so
   // the memory outputs take the live request fields instead.
   always_comb begin
      cur_write_s = write_r;
      cur_byte_s  = byte_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      if (accept_s) begin
         cur_write_s = req_write;
         cur_byte_s  = req_byte;
         cur_addr_s  = req_addr;
         cur_wdata_s = req_wdata;
      end else begin
         cur_write_s = write_r;
      end
      drive_s = (next_state_s == SETUP) || (next_state_s == ACCESS) ||
                (next_state_s == HOLD);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         cnt_r   <= next_cnt_s;
      end
   end

   // Request capture at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_r  <= 1'b0;
         byte_r   <= 1'b0;
         signed_r <= 1'b0;
         addr_r   <= 32'd0;
         wdata_r  <= {DATA_W{1'b0}};
         tag_r    <= {TAG_W{1'b0}};
      end else if (accept_s) begin
         write_r  <= req_write;
         byte_r   <= req_byte;
         signed_r <= req_signed;
         addr_r   <= req_addr;
         wdata_r  <= req_wdata;
         tag_r    <= req_tag;
      end
   end

   // Registered memory-side outputs and request handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready          <= 1'b1;
         mem_address        <= {ADDR_W{1'b0}};
         mem_write_data     <= {DATA_W{1'b0}};
         mem_byteOperations <= 1'b0;
         mem_memRead        <= 1'b0;
         mem_memWrite       <= 1'b0;
      end else begin
         req_ready    <= (next_state_s == IDLE);
         mem_memRead  <= (next_state_s == ACCESS) && !cur_write_s;
         mem_memWrite <= (next_state_s == ACCESS) && cur_write_s;
         if (drive_s) begin
            mem_address        <= cur_addr_s[ADDR_W-1:0];
            mem_write_data     <= cur_byte_s ? {{(DATA_W-8){1'b0}}, cur_wdata_s[7:0]}
                                             : cur_wdata_s;
            mem_byteOperations <= cur_byte_s;
         end else begin
            mem_address        <= {ADDR_W{1'b0}};
            mem_write_data     <= {DATA_W{1'b0}};
            mem_byteOperations <= 1'b0;
         end
      end
   end

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .raw       (mem_read_data),
      .is_byte   (byte_r),
      .is_signed (signed_r),
      .ext       (ext_s)
   );

   // Read data is sampled on the edge that closes the last strobe cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_r <= {DATA_W{1'b0}};
      end else if ((state_r == ACCESS) && (next_state_s == HOLD)) begin
         load_r <= ext_s;
      end
   end

   // Response register: loaded on entry to RESP, cleared when consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_rdata <= {DATA_W{1'b0}};
         resp_tag   <= {TAG_W{1'b0}};
         resp_err   <= 1'b0;
      end else if ((state_r != RESP) && (next_state_s == RESP)) begin
         resp_valid <= 1'b1;
         resp_tag   <= (state_r == IDLE) ? req_tag : tag_r;
         resp_err   <= (state_r == IDLE);
         resp_rdata <= ((state_r == IDLE) || write_r) ? {DATA_W{1'b0}} : load_r;
      end else if ((state_r == RESP) && (next_state_s == IDLE)) begin
         resp_valid <= 1'b0;
         resp_rdata <= {DATA_W{1'b0}};
         resp_tag   <= {TAG_W{1'b0}};
         resp_err   <= 1'b0;
      end
   end

endmodule
